// File: rtl/bp_pkg.sv
// Shared types for the branch predictor PHT path.
//   ctr_t      : 2-bit saturating direction counter
//   SNT..ST    : counter encodings (strong/weak not-taken/taken)
//   state_t    : PHT sequencer state (INIT sweep, RUN)
//   sat_update : next counter value for a resolved branch
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'd0;
    localparam ctr_t WNT = 2'd1;
    localparam ctr_t WT  = 2'd2;
    localparam ctr_t ST  = 2'd3;

    typedef enum logic {INIT, RUN} state_t;

    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        if (taken)
            return (ctr == ST) ? ST : ctr + 2'd1;
        else
            return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// Resolve-update queue for the PHT sequencer.
//   clk, rst            : clock, async active-high reset
//   flush               : drop every queued entry
//   push, push_*        : enqueue {index, ctr, taken}
//   pop                 : dequeue head (caller guarantees non-empty)
//   head_*              : oldest entry
//   full, empty, count  : occupancy
//   ent_*, ent_vld      : all entries in age order (slot 0 = oldest), for
//                         lookup forwarding
module pht_upd_fifo
    import bp_pkg::*;
#(
    parameter int IDX_W  = 10,
    parameter int QDEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             push,
    input  logic [IDX_W-1:0]                 push_index,
    input  ctr_t                             push_ctr,
    input  logic                             push_taken,
    input  logic                             pop,
    output logic [IDX_W-1:0]                 head_index,
    output ctr_t                             head_ctr,
    output logic                             head_taken,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(QDEPTH):0]          count,
    output logic [QDEPTH-1:0][IDX_W-1:0]     ent_index,
    output ctr_t [QDEPTH-1:0]                ent_ctr,
    output logic [QDEPTH-1:0]                ent_taken,
    output logic [QDEPTH-1:0]                ent_vld
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [IDX_W-1:0] q_index [QDEPTH];
    ctr_t             q_ctr   [QDEPTH];
    logic             q_taken [QDEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Payload needs no reset: nothing reads a slot before it is written.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            q_index[wr_ptr] <= push_index;
            q_ctr[wr_ptr]   <= push_ctr;
            q_taken[wr_ptr] <= push_taken;
        end
    end

    assign full       = (count == CW'(QDEPTH));
    assign empty      = (count == '0);
    assign head_index = q_index[rd_ptr];
    assign head_ctr   = q_ctr[rd_ptr];
    assign head_taken = q_taken[rd_ptr];

    // Rotate storage so the consumer sees entries oldest-first.
    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            ent_index[i] = q_index[rd_ptr + PW'(i)];
            ent_ctr[i]   = q_ctr[rd_ptr + PW'(i)];
            ent_taken[i] = q_taken[rd_ptr + PW'(i)];
            ent_vld[i]   = (CW'(i) < count);
        end
    end

endmodule

// File: rtl/pht_access_ctrl.sv
// PHT SRAM sequencer: initialises a single-port, synchronous-read table of
// 2-bit counters, then arbitrates between IF-stage lookups and queued
// EX-stage resolve updates (read-modify-write done from the queued ctr).
//   clk, rst                        : clock, async active-high reset
//   init_req                        : flush queue and restart init sweep
//   lk_valid/lk_index/lk_ready      : lookup request handshake
//   lk_rvalid/lk_rdata              : lookup result, one cycle after accept
//   up_valid/up_index/up_ctr/up_taken/up_ready : resolve update enqueue
//   init_done                       : table initialised, RUN state
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : SRAM port
// Build option: define PHT_FWD_EN to forward pending queued updates into
// lookup results so they never return a stale counter.
module pht_access_ctrl
    import bp_pkg::*;
#(
    parameter int   IDX_W      = 10,
    parameter int   QDEPTH     = 4,
    parameter ctr_t INIT_CTR   = WT,
    parameter int   STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_req,
    input  logic             lk_valid,
    input  logic [IDX_W-1:0] lk_index,
    output logic             lk_ready,
    output logic             lk_rvalid,
    output ctr_t             lk_rdata,
    input  logic             up_valid,
    input  logic [IDX_W-1:0] up_index,
    input  ctr_t             up_ctr,
    input  logic             up_taken,
    output logic             up_ready,
    output logic             init_done,
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_addr,
    output ctr_t             mem_wdata,
    input  ctr_t             mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int CW = $clog2(QDEPTH) + 1;

    state_t                      state;
    logic [IDX_W-1:0]            sweep_addr;
    logic [SW-1:0]               starve;

    logic                        q_full, q_empty;
    logic [CW-1:0]               q_count;
    logic [IDX_W-1:0]            head_index;
    ctr_t                        head_ctr;
    logic                        head_taken;
    logic [QDEPTH-1:0][IDX_W-1:0] ent_index;
    ctr_t [QDEPTH-1:0]           ent_ctr;
    logic [QDEPTH-1:0]           ent_taken, ent_vld;

    logic                        run, wr_slot, lk_accept, push;
    ctr_t                        rd_data, rdata_hold;

    // init_req takes the whole cycle: no lookup, no update write, no enqueue.
    assign run       = (state == RUN) && !init_req;
    assign wr_slot   = run && !q_empty &&
                       (!lk_valid || q_full || starve == SW'(STARVE_MAX));
    assign lk_ready  = run && !wr_slot;
    assign up_ready  = run && !q_full;
    assign lk_accept = lk_valid && lk_ready;
    assign push      = up_valid && up_ready;

    pht_upd_fifo #(.IDX_W(IDX_W), .QDEPTH(QDEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (init_req),
        .push       (push),
        .push_index (up_index),
        .push_ctr   (up_ctr),
        .push_taken (up_taken),
        .pop        (wr_slot),
        .head_index (head_index),
        .head_ctr   (head_ctr),
        .head_taken (head_taken),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_count),
        .ent_index  (ent_index),
        .ent_ctr    (ent_ctr),
        .ent_taken  (ent_taken),
        .ent_vld    (ent_vld)
    );

    // SRAM command. State resets to INIT, so the sweep write is gated by rst
    // to keep the port quiet while reset is held.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == INIT && !init_req && !rst) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = sweep_addr;
            mem_wdata = INIT_CTR;
        end else if (wr_slot) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = head_index;
            mem_wdata = sat_update(head_ctr, head_taken);
        end else if (lk_accept) begin
            mem_en    = 1'b1;
            mem_addr  = lk_index;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            sweep_addr <= '0;
            starve     <= '0;
            init_done  <= 1'b0;
        end else if (init_req) begin
            state      <= INIT;
            sweep_addr <= '0;
            starve     <= '0;
            init_done  <= 1'b0;
        end else if (state == INIT) begin
            sweep_addr <= sweep_addr + IDX_W'(1);
            if (sweep_addr == '1) begin
                state     <= RUN;
                init_done <= 1'b1;
            end
        end else begin
            if (wr_slot || q_empty)
                starve <= '0;
            else if (lk_accept)
                starve <= starve + SW'(1);
        end
    end

`ifdef PHT_FWD_EN
    // A write slot never coincides with an accepted lookup, so the entry
    // being written that cycle is still in the queue view when compared.
    logic fwd_hit, fwd_hit_q;
    ctr_t fwd_val, fwd_val_q;
    logic unused_sigs;

    always_comb begin
        fwd_hit = 1'b0;
        fwd_val = '0;
        // Oldest-first scan: the last hit is the youngest matching entry.
        for (int i = 0; i < QDEPTH; i++) begin
            if (ent_vld[i] && ent_index[i] == lk_index) begin
                fwd_hit = 1'b1;
                fwd_val = sat_update(ent_ctr[i], ent_taken[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_hit_q <= 1'b0;
            fwd_val_q <= '0;
        end else if (lk_accept) begin
            fwd_hit_q <= fwd_hit;
            fwd_val_q <= fwd_val;
        end
    end

    assign rd_data     = fwd_hit_q ? fwd_val_q : mem_rdata;
    assign unused_sigs = ^q_count;
`else
    logic unused_sigs;
    assign rd_data     = mem_rdata;
    assign unused_sigs = ^{q_count, ent_index, ent_ctr, ent_taken, ent_vld};
`endif

    // lk_rvalid is a flop; the data beat comes straight from the SRAM in the
    // response cycle and is held in rdata_hold afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk_rvalid  <= 1'b0;
            rdata_hold <= '0;
        end else begin
            lk_rvalid <= lk_accept;
            if (lk_rvalid) rdata_hold <= rd_data;
        end
    end

    assign lk_rdata = lk_rvalid ? rd_data : rdata_hold;

endmodule

// File: tb/tb_pht_access_ctrl.sv
// Directed bench for pht_access_ctrl (IDX_W=4, QDEPTH=4, STARVE_MAX=8).
module tb_pht_access_ctrl;

    localparam int IDX_W = 4;

`ifdef PHT_FWD_EN
    localparam logic [1:0] FWD_EXP = 2'd0;
`else
    localparam logic [1:0] FWD_EXP = 2'd2;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             init_req = 1'b0;
    logic             lk_valid = 1'b0;
    logic [IDX_W-1:0] lk_index = '0;
    logic             up_valid = 1'b0;
    logic [IDX_W-1:0] up_index = '0;
    logic [1:0]       up_ctr = '0;
    logic             up_taken = 1'b0;
    logic             lk_ready, lk_rvalid, up_ready, init_done, mem_en, mem_we;
    logic [1:0]       lk_rdata, mem_wdata;
    logic [IDX_W-1:0] mem_addr;
    logic [1:0]       mem_rdata = '0;
    logic [1:0]       sram [16];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Synchronous-read SRAM model.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr];
        end
    end

    pht_access_ctrl #(.IDX_W(IDX_W), .QDEPTH(4), .INIT_CTR(2'b10), .STARVE_MAX(8)) dut (
        .clk(clk), .rst(rst), .init_req(init_req),
        .lk_valid(lk_valid), .lk_index(lk_index), .lk_ready(lk_ready),
        .lk_rvalid(lk_rvalid), .lk_rdata(lk_rdata),
        .up_valid(up_valid), .up_index(up_index), .up_ctr(up_ctr), .up_taken(up_taken),
        .up_ready(up_ready), .init_done(init_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] got, exp;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, lk_ready, up_ready, init_done, lk_rvalid, lk_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {mem_en, mem_we, mem_addr, mem_wdata, lk_ready, up_ready, init_done, lk_rvalid, lk_rdata});
        end
        nxt();
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            got = {mem_en, mem_we, mem_addr, mem_wdata, lk_ready, up_ready, init_done};
            exp = {1'b1, 1'b1, 4'(k), 2'd2, 3'b000};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL sweep_write_%0d: got %h required %h", k, got, exp);
            end
            nxt();
        end
        @(negedge clk);
        n_cmp++;
        if ({init_done, mem_en, lk_ready, up_ready} !== 4'b1011) begin
            n_bad++;
            $display("FAIL init_done_rise: got %b required 1011", {init_done, mem_en, lk_ready, up_ready});
        end
        nxt();
    endtask

    task automatic test_update_sat();
        up_valid = 1'b1; up_index = 4'd3; up_ctr = 2'd3; up_taken = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({up_ready, mem_en} !== 2'b10) begin
            n_bad++;
            $display("FAIL upd_first_cycle: got %b required 10", {up_ready, mem_en});
        end
        nxt();
        up_index = 4'd5; up_ctr = 2'd0; up_taken = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'd3, 2'd3}) begin
            n_bad++;
            $display("FAIL upd_sat_high: got %h required %h", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'd3, 2'd3});
        end
        nxt();
        up_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'd5, 2'd0}) begin
            n_bad++;
            $display("FAIL upd_sat_low: got %h required %h", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'd5, 2'd0});
        end
        nxt();
        @(negedge clk);
        n_cmp++;
        if (mem_en !== 1'b0) begin
            n_bad++;
            $display("FAIL upd_drained: got mem_en=%b required 0", mem_en);
        end
        nxt();
    endtask

    task automatic test_lookup();
        lk_valid = 1'b1; lk_index = 4'd5;
        @(negedge clk);
        n_cmp++;
        if ({lk_ready, mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 4'd5}) begin
            n_bad++;
            $display("FAIL lk_read_issue: got %h required %h", {lk_ready, mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 1'b0, 4'd5});
        end
        nxt();
        lk_index = 4'd3;
        @(negedge clk);
        n_cmp++;
        if ({lk_rvalid, lk_rdata} !== {1'b1, 2'd0}) begin
            n_bad++;
            $display("FAIL lk_resp_idx5: got %b required 100", {lk_rvalid, lk_rdata});
        end
        nxt();
        lk_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({lk_rvalid, lk_rdata} !== {1'b1, 2'd3}) begin
            n_bad++;
            $display("FAIL lk_resp_idx3: got %b required 111", {lk_rvalid, lk_rdata});
        end
        nxt();
        @(negedge clk);
        n_cmp++;
        if ({lk_rvalid, lk_rdata} !== {1'b0, 2'd3}) begin
            n_bad++;
            $display("FAIL lk_rdata_hold: got %b required 011", {lk_rvalid, lk_rdata});
        end
        nxt();
    endtask

    task automatic test_starve();
        int wins = 0;
        up_valid = 1'b1; up_index = 4'd9; up_ctr = 2'd1; up_taken = 1'b0;
        nxt();
        up_valid = 1'b0; lk_valid = 1'b1; lk_index = 4'd0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (lk_ready) wins++;
            nxt();
        end
        n_cmp++;
        if (wins !== 8) begin
            n_bad++;
            $display("FAIL starve_wins: got %0d required 8", wins);
        end
        @(negedge clk);
        n_cmp++;
        if ({lk_ready, mem_we, mem_addr, mem_wdata} !== {1'b0, 1'b1, 4'd9, 2'd0}) begin
            n_bad++;
            $display("FAIL starve_forced_wr: got %h required %h", {lk_ready, mem_we, mem_addr, mem_wdata}, {1'b0, 1'b1, 4'd9, 2'd0});
        end
        nxt();
        @(negedge clk);
        n_cmp++;
        if (lk_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL starve_after_wr: got lk_ready=%b required 1", lk_ready);
        end
        nxt();
        lk_valid = 1'b0;
    endtask

    task automatic test_fill();
        int fidx [4] = '{10, 11, 10, 12};
        int fctr [4] = '{2, 1, 3, 0};
        int ftk  [4] = '{1, 0, 1, 1};
        int fnew [4] = '{3, 0, 3, 1};
        logic rdy = 1'b1;
        lk_valid = 1'b1; lk_index = 4'd1;
        for (int k = 0; k < 4; k++) begin
            up_valid = 1'b1; up_index = 4'(fidx[k]); up_ctr = 2'(fctr[k]); up_taken = ftk[k][0];
            @(negedge clk);
            rdy = rdy & up_ready & lk_ready;
            nxt();
        end
        up_valid = 1'b0;
        n_cmp++;
        if (rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_ready: got %b required 1", rdy);
        end
        @(negedge clk);
        n_cmp++;
        if ({up_ready, lk_ready, mem_en, mem_we, mem_addr, mem_wdata} !== {1'b0, 1'b0, 1'b1, 1'b1, 4'd10, 2'd3}) begin
            n_bad++;
            $display("FAIL full_forced_wr: got %h required %h",
                     {up_ready, lk_ready, mem_en, mem_we, mem_addr, mem_wdata}, {1'b0, 1'b0, 1'b1, 1'b1, 4'd10, 2'd3});
        end
        nxt();
        @(negedge clk);
        n_cmp++;
        if ({up_ready, lk_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL full_recover: got %b required 11", {up_ready, lk_ready});
        end
        nxt();
        lk_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'(fidx[k]), 2'(fnew[k])}) begin
                n_bad++;
                $display("FAIL fifo_drain_%0d: got %h required %h", k,
                         {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'(fidx[k]), 2'(fnew[k])});
            end
            nxt();
        end
        @(negedge clk);
        n_cmp++;
        if (mem_en !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_drained: got mem_en=%b required 0", mem_en);
        end
        nxt();
    endtask

    task automatic test_fwd();
        up_valid = 1'b1; up_index = 4'd7; up_ctr = 2'd0; up_taken = 1'b0;
        nxt();
        up_valid = 1'b0; lk_valid = 1'b1; lk_index = 4'd7;
        @(negedge clk);
        n_cmp++;
        if (lk_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL fwd_lk_accept: got lk_ready=%b required 1", lk_ready);
        end
        nxt();
        lk_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({lk_rvalid, lk_rdata} !== {1'b1, FWD_EXP}) begin
            n_bad++;
            $display("FAIL fwd_rdata: got %b required %b", {lk_rvalid, lk_rdata}, {1'b1, FWD_EXP});
        end
        n_cmp++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'd7, 2'd0}) begin
            n_bad++;
            $display("FAIL fwd_drain_wr: got %h required %h", {mem_we, mem_addr, mem_wdata}, {1'b1, 4'd7, 2'd0});
        end
        nxt();
    endtask

    task automatic test_init_req();
        int iidx [3] = '{3, 4, 5};
        int ictr [3] = '{0, 0, 3};
        int bad = 0;
        lk_valid = 1'b1; lk_index = 4'd2;
        for (int k = 0; k < 3; k++) begin
            up_valid = 1'b1; up_index = 4'(iidx[k]); up_ctr = 2'(ictr[k]); up_taken = 1'b1;
            nxt();
        end
        up_index = 4'd6; up_ctr = 2'd0; init_req = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({lk_rvalid, lk_ready, up_ready, mem_en} !== 4'b1000) begin
            n_bad++;
            $display("FAIL initreq_cycle: got %b required 1000", {lk_rvalid, lk_ready, up_ready, mem_en});
        end
        nxt();
        init_req = 1'b0; up_valid = 1'b0; lk_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({init_done, mem_en, mem_we, mem_addr, mem_wdata} !== {1'b0, 1'b1, 1'b1, 4'd0, 2'd2}) begin
            n_bad++;
            $display("FAIL initreq_restart: got %h required %h",
                     {init_done, mem_en, mem_we, mem_addr, mem_wdata}, {1'b0, 1'b1, 1'b1, 4'd0, 2'd2});
        end
        for (int k = 1; k < 16; k++) begin
            nxt();
            @(negedge clk);
            if (!(mem_en && mem_we && mem_wdata == 2'd2 && mem_addr == 4'(k))) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL initreq_sweep: got %0d bad writes required 0", bad);
        end
        nxt();
        @(negedge clk);
        n_cmp++;
        if ({init_done, mem_en} !== 2'b10) begin
            n_bad++;
            $display("FAIL initreq_flushed: got %b required 10", {init_done, mem_en});
        end
        nxt();
    endtask

    task automatic test_rst_mid_sweep();
        int cyc = 0;
        init_req = 1'b1;
        nxt();
        init_req = 1'b0;
        repeat (5) nxt();
        @(negedge clk);
        n_cmp++;
        if (mem_addr !== 4'd5) begin
            n_bad++;
            $display("FAIL midsweep_addr: got %0d required 5", mem_addr);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({mem_en, init_done, lk_ready} !== 3'b000) begin
            n_bad++;
            $display("FAIL async_rst: got %b required 000", {mem_en, init_done, lk_ready});
        end
        nxt();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 4'd0}) begin
            n_bad++;
            $display("FAIL rst_restart: got %h required %h", {mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 4'd0});
        end
        while (!init_done && cyc < 40) begin
            nxt();
            cyc++;
        end
        n_cmp++;
        if (cyc !== 16) begin
            n_bad++;
            $display("FAIL rst_sweep_len: got %0d cycles required 16", cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_update_sat();
        test_lookup();
        test_starve();
        test_fill();
        test_fwd();
        test_init_req();
        test_rst_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
